// File: rtl/rom_arb_pkg.sv
// Shared constants for the ROM read arbiter: macro geometry, default read latency
// and the requester-id width helper.
package rom_arb_pkg;
    localparam int ROM_ADDR_WIDTH  = 10;
    localparam int ROM_DATA_WIDTH  = 8;
    localparam int ROM_DEPTH       = 1024;
    localparam int DEF_ROM_LATENCY = 1;

    // Never returns 0, so a degenerate single-requester build still gets a legal vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rom_read_arbiter_rr.sv
// Pointer-based round-robin arbiter: one-hot grant plus encoded index.
// The scan starts at the pointer, and the pointer moves past the winner after each grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!gnt_any && !reset && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_any   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (gnt_any)
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one single-port ROM macro between NUM_REQ readers: round-robin issue,
// a tag pipeline matched to the macro latency, and a registered tagged response.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = ROM_DATA_WIDTH,
    parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [id_width(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rom_cs,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_dout,
    output logic                          busy
);
    localparam int IW     = id_width(NUM_REQ);
    localparam int STAGES = ROM_LATENCY - 1;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [IW-1:0]                      gnt_idx;
    logic                               gnt_any;
    logic [ADDR_WIDTH-1:0]              addr_q;
    logic [STAGES:0]                    vld_pipe;
    logic [STAGES:0][IW-1:0]            id_pipe;

    assign addr_arr = req_addr;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The macro samples cs/addr at the next edge, so issue is purely combinational;
    // addr_q keeps the bus quiet between reads.
    assign rom_cs   = gnt_any;
    assign rom_addr = gnt_any ? addr_arr[gnt_idx] : addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            vld_pipe  <= '0;
            id_pipe   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            addr_q      <= rom_addr;
            vld_pipe[0] <= gnt_any;
            id_pipe[0]  <= gnt_idx;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
            // Last stage lines up with the cycle rom_dout is valid for that tag.
            rsp_valid <= vld_pipe[STAGES];
            if (vld_pipe[STAGES]) begin
                rsp_id   <= id_pipe[STAGES];
                rsp_data <= rom_dout;
            end
        end
    end

    assign busy = (|vld_pipe) | rsp_valid;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: latency-1 and latency-2 builds share one stimulus stream,
// each against its own ROM macro model and a queue-based response scoreboard.
module tb_rom_read_arbiter;
    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;

    logic [NR-1:0] req_ready1, req_ready2;
    logic          rsp_valid1, rsp_valid2, rom_cs1, rom_cs2, busy1, busy2;
    logic [1:0]    rsp_id1, rsp_id2;
    logic [DW-1:0] rsp_data1, rsp_data2, rom_dout1, rom_dout2, rom_q2a;
    logic [AW-1:0] rom_addr1, rom_addr2;

    always #5 clk = ~clk;

    rom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_data(rsp_data1),
        .rom_cs(rom_cs1), .rom_addr(rom_addr1), .rom_dout(rom_dout1), .busy(busy1));

    rom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_data(rsp_data2),
        .rom_cs(rom_cs2), .rom_addr(rom_addr2), .rom_dout(rom_dout2), .busy(busy2));

    // ROM image: a fixed scramble of the address stands in for the .hex file.
    function automatic logic [7:0] rom_val(input int a);
        return 8'((a * 37) ^ (a >> 5) ^ 8'hA5);
    endfunction

    logic [7:0] mem [1024];
    initial for (int a = 0; a < 1024; a++) mem[a] = rom_val(a);

    always @(posedge clk) if (rom_cs1) rom_dout1 <= mem[rom_addr1];
    always @(posedge clk) begin
        if (rom_cs2) rom_q2a <= mem[rom_addr2];
        rom_dout2 <= rom_q2a;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: expected responses are queued at accept time with their due cycle.
    typedef struct { int id; logic [7:0] data; int due; } exp_t;
    exp_t q1[$];
    exp_t q2[$];
    int         mptr  = 0;
    int         cyc   = 0;
    logic [9:0] maddr = '0;
    logic [7:0] last1 = '0, last2 = '0;
    bit         en    = 1'b0;

    always @(negedge clk) begin
        int g;
        int p;
        logic [NR-1:0] exp_rdy;
        if (en) begin
            chk("busy_l1", busy1, q1.size() != 0);
            chk("busy_l2", busy2, q2.size() != 0);
            if (q1.size() != 0 && q1[0].due == cyc) begin
                chk("rsp_valid_l1", rsp_valid1, 1);
                chk("rsp_id_l1", rsp_id1, q1[0].id);
                chk("rsp_data_l1", rsp_data1, q1[0].data);
                last1 = q1[0].data;
                void'(q1.pop_front());
            end else begin
                chk("rsp_idle_l1", rsp_valid1, 0);
                chk("rsp_hold_l1", rsp_data1, last1);
            end
            if (q2.size() != 0 && q2[0].due == cyc) begin
                chk("rsp_valid_l2", rsp_valid2, 1);
                chk("rsp_id_l2", rsp_id2, q2[0].id);
                chk("rsp_data_l2", rsp_data2, q2[0].data);
                last2 = q2[0].data;
                void'(q2.pop_front());
            end else begin
                chk("rsp_idle_l2", rsp_valid2, 0);
                chk("rsp_hold_l2", rsp_data2, last2);
            end
            g = -1;
            if (!reset)
                for (int k = 0; k < NR; k++) begin
                    p = (mptr + k) % NR;
                    if (g < 0 && req_valid[p]) g = p;
                end
            exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
            chk("ready_l1", req_ready1, exp_rdy);
            chk("ready_l2", req_ready2, exp_rdy);
            chk("rom_cs_l1", rom_cs1, g >= 0);
            chk("rom_cs_l2", rom_cs2, g >= 0);
            if (g >= 0) begin
                maddr = req_addr[g*AW +: AW];
                q1.push_back('{g, rom_val(int'(maddr)), cyc + 2});
                q2.push_back('{g, rom_val(int'(maddr)), cyc + 3});
                mptr = (g + 1) % NR;
            end
            chk("rom_addr_l1", rom_addr1, maddr);
            chk("rom_addr_l2", rom_addr2, maddr);
            if (reset) begin
                q1.delete();
                q2.delete();
                mptr  = 0;
                maddr = '0;
                last1 = '0;
                last2 = '0;
            end
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs;
        chk("rst_ready", {req_ready1, req_ready2}, 0);
        chk("rst_rsp_valid", {rsp_valid1, rsp_valid2}, 0);
        chk("rst_rsp_id", {rsp_id1, rsp_id2}, 0);
        chk("rst_rsp_data", {rsp_data1, rsp_data2}, 0);
        chk("rst_rom_cs", {rom_cs1, rom_cs2}, 0);
        chk("rst_rom_addr", {rom_addr1, rom_addr2}, 0);
        chk("rst_busy", {busy1, busy2}, 0);
    endtask

    typedef struct { logic [3:0] v; logic [3:0] rdy; } vec_t;
    vec_t tbl [14];
    int   gcnt [NR];

    initial begin
        // Hand-derived grant sequence from pointer 0; rows 12-13 are the pointer=3 wraparound.
        tbl[0]  = '{4'b1111, 4'b0001};  tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1001, 4'b1000};  tbl[3]  = '{4'b1001, 4'b0001};
        tbl[4]  = '{4'b0000, 4'b0000};  tbl[5]  = '{4'b0101, 4'b0100};
        tbl[6]  = '{4'b0011, 4'b0001};  tbl[7]  = '{4'b0011, 4'b0010};
        tbl[8]  = '{4'b1000, 4'b1000};  tbl[9]  = '{4'b1000, 4'b1000};
        tbl[10] = '{4'b0110, 4'b0010};  tbl[11] = '{4'b1100, 4'b0100};
        tbl[12] = '{4'b1001, 4'b1000};  tbl[13] = '{4'b1001, 4'b0001};

        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        en    = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        tick();

        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            for (int p = 0; p < NR; p++) req_addr[p*AW +: AW] = AW'($urandom_range(0, 1023));
            @(negedge clk);
            chk("tbl_ready", req_ready1, tbl[i].rdy);
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // Port 2 streams the whole ROM back to back.
        for (int a = 0; a < 1024; a++) begin
            req_valid = 4'b0100;
            req_addr[2*AW +: AW] = AW'(a);
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // All four ports held valid from reset: strict rotation, 25% each.
        do_reset();
        req_addr = {10'h040, 10'h030, 10'h020, 10'h010};
        req_valid = 4'b1111;
        foreach (gcnt[p]) gcnt[p] = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int p = 0; p < NR; p++) if (req_ready1[p]) gcnt[p]++;
            tick();
        end
        for (int p = 0; p < NR; p++) chk("share", gcnt[p], 10);
        req_valid = '0;
        repeat (4) tick();

        // Sparse: port 3, idle gap, then ports 1 and 3 both valid; pointer must still be 0.
        do_reset();
        req_valid = 4'b1000;
        req_addr[3*AW +: AW] = 10'h123;
        tick();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_cs", rom_cs1, 0);
            tick();
        end
        req_valid = 4'b1010;
        req_addr[1*AW +: AW] = 10'h055;
        @(negedge clk);
        chk("sparse_ptr", req_ready1, 4'b0010);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset the cycle after accepting 0x3FF: nothing comes back, pointer returns to 0.
        do_reset();
        req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 10'h3FF;
        @(negedge clk);
        chk("rst_accept", req_ready1, 4'b0010);
        tick();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("rst_no_rsp", {rsp_valid1, rsp_valid2}, 0);
        end
        tick();
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_ptr0", req_ready1, 4'b0001);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(0, 15));
            for (int p = 0; p < NR; p++) req_addr[p*AW +: AW] = AW'($urandom_range(0, 1023));
            tick();
        end
        reset     = 1'b0;
        req_valid = '0;
        repeat (6) tick();
        chk("drain_l1", q1.size(), 0);
        chk("drain_l2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
